fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register of the 5-stage RV32I core.
//  - Generates the PC and drives a single-outstanding imem request/response handshake.
//  - Honours stall_f/stall_d from the hazard detector and EX-stage branch/jump redirects.
//  - Presents pc/inst/valid to decode, where rs1/rs2 are extracted for the hazard detector.
// PARAMETERS
//  RESET_PC   32'h0000_0000   first fetch address after reset
//  NOP_INST   32'h0000_0013   instruction held in IF/ID when invalid (addi x0,x0,0)
// PORTS
//  clk            in   1   clock; all state on rising edge
//  rst_n          in   1   asynchronous active-low reset
//  stall_f        in   1   hazard stall: freeze PC, accept no new instruction
//  stall_d        in   1   hazard stall: hold IF/ID contents
//  redirect       in   1   EX taken branch/jump; also flushes IF/ID
//  redirect_pc    in   32  redirect target
//  imem_req       out  1   one-cycle request pulse
//  imem_addr      out  32  request address (valid with imem_req)
//  imem_rvalid    in   1   response valid; latency >=1 cycle after imem_req
//  imem_rdata     in   32  instruction word, valid with imem_rvalid
//  pc_dec         out  32  IF/ID PC
//  pc4_dec        out  32  IF/ID PC+4
//  inst_dec       out  32  IF/ID instruction
//  valid_dec      out  1   IF/ID holds a real instruction
//  fetch_misalign out  1   misaligned-target trap (0 when FETCH_MISALIGN_EN undefined)
// BEHAVIOUR
//  Reset: state=IDLE, pc_q=RESET_PC, imem_req=0, imem_addr=RESET_PC, valid_dec=0,
//   inst_dec=NOP_INST, pc_dec=0, pc4_dec=0, hold buffer empty, fetch_misalign=0.
//  adv = !stall_f & !stall_d. At most one request outstanding. PC arithmetic mod 2^32.
//  States: IDLE, WAIT (keep response), DROP (discard response), HOLD (buffered inst).
//  IDLE: issue req at pc_q -> WAIT. Redirect in IDLE: pc_q<=redirect_pc, stay IDLE.
//   rvalid in IDLE ignored.
//  WAIT, rvalid, adv, !redirect: IF/ID <= {pc_q, pc_q+4, rdata, 1}; same cycle issue
//   req at pc_q+4; pc_q+=4; stay WAIT (1-cycle memory => 1 inst/cycle).
//  WAIT, rvalid, !adv, !redirect: rdata -> hold buffer, no req -> HOLD.
//  WAIT, redirect: pc_q<=redirect_pc; if rvalid same cycle, drop it, issue req at
//   redirect_pc -> WAIT; else -> DROP.
//  DROP: rvalid discarded, issue req at pc_q -> WAIT. Redirect in DROP: update pc_q only.
//  HOLD, adv, !redirect: buffer -> IF/ID, issue req at pc_q+4, pc_q+=4 -> WAIT.
//  HOLD, redirect: clear buffer, issue req at redirect_pc -> WAIT.
//  Priority: redirect > stall. Stalls never drop or duplicate an instruction.
//  IF/ID: redirect -> valid_dec=0, inst_dec=NOP_INST; else stall_d -> hold;
//   else new inst if delivered, otherwise bubble (valid_dec=0, inst_dec=NOP_INST).
//  Reset mid-request: all state returns to reset values at once; in-flight response
//   arrives in IDLE and is ignored.
// CONFIGURATION
//  FETCH_MISALIGN_EN defined: redirect with redirect_pc[1:0]!=0 -> state TRAP; no
//   requests; fetch_misalign=1; IF/ID bubbles. TRAP exits only on an aligned redirect
//   (-> req at target, WAIT) or reset. Misaligned redirect while in TRAP: stay TRAP.
//  Undefined: redirect_pc[1:0] forced to 2'b00; no TRAP state; fetch_misalign tied 0.
// TESTING
//  T1 reset release, 1-cycle imem returning 0x13,0x93,0x113 -> imem_addr 0,4,8 on
//     consecutive cycles; pc_dec 0,4,8 with valid_dec=1 on cycles 2,3,4.
//  T2 stall_f=stall_d=1 for 3 cycles while response at 0x8 returns -> no imem_req,
//     IF/ID frozen; after release inst from 0x8 in IF/ID, next req at 0xC.
//  T3 3-cycle imem, redirect to 0x100 one cycle after req to 0x4 -> 0x4 response
//     dropped, next req 0x100, valid_dec=0 until pc_dec=0x100 appears.
//  T4 redirect to 0x40 with stall_f=stall_d=1 in HOLD -> buffer cleared, req 0x40,
//     valid_dec=0 next cycle.
//  T5 rst_n low during WAIT -> outputs reset asynchronously; late rvalid ignored;
//     first post-reset req addr=RESET_PC.
//  T6 (FETCH_MISALIGN_EN) redirect to 0x102 -> fetch_misalign=1, no req;
//     redirect to 0x200 -> fetch_misalign=0, req at 0x200.

Source files
------------

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Instruction-memory request/response bundle used by the
//                fetch stage. Single outstanding request; the response comes
//                back one or more cycles after the request pulse.
//                  imem_req    fetch -> mem  one-cycle request pulse
//                  imem_addr   fetch -> mem  request address (valid with req)
//                  imem_rvalid mem -> fetch  response valid
//                  imem_rdata  mem -> fetch  instruction word (with rvalid)
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    // Fetch stage side
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    // Instruction memory side
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : RV32I instruction-fetch stage plus IF/ID pipeline register.
//                Generates the PC, runs a single-outstanding imem handshake,
//                honours hazard stalls and EX-stage redirects.
//  Ports       : clk, rst_n (async, active low)
//                stall_f / stall_d   hazard stalls (fetch / decode)
//                redirect, redirect_pc  EX taken branch/jump target
//                imem                fetch_stage_if.master instruction bus
//                pc_dec, pc4_dec, inst_dec, valid_dec   IF/ID contents
//                fetch_misalign      misaligned-target trap flag
//  Config      : define FETCH_MISALIGN_EN to trap on redirect targets with
//                non-zero low bits; otherwise the low bits are forced to 00
//                and fetch_misalign is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        stall_f,
    input  wire logic        stall_d,
    input  wire logic        redirect,
    input  wire logic [31:0] redirect_pc,
    fetch_stage_if.master    imem,
    output logic      [31:0] pc_dec,
    output logic      [31:0] pc4_dec,
    output logic      [31:0] inst_dec,
    output logic             valid_dec,
    output logic             fetch_misalign
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,   // no request outstanding, issue one at pc_q
        S_WAIT = 3'd1,   // request for pc_q outstanding, keep its response
        S_DROP = 3'd2,   // stale request outstanding, discard its response
        S_HOLD = 3'd3,   // instruction for pc_q parked in hold buffer
        S_TRAP = 3'd4    // misaligned redirect target, fetch halted
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic        run_q, run_d;
    logic [31:0] pc_dec_q, pc_dec_d;
    logic [31:0] pc4_dec_q, pc4_dec_d;
    logic [31:0] inst_dec_q, inst_dec_d;
    logic        valid_dec_q, valid_dec_d;

    logic        adv;
    logic [31:0] pc_plus4;
    logic [31:0] tgt;
    logic        tgt_bad;
    logic        req;
    logic [31:0] addr;
    logic        deliver;
    logic [31:0] deliver_inst;

    assign adv      = !stall_f && !stall_d;
    assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_MISALIGN_EN
    // Tracks a response still in flight when the trap was taken, so that
    // leaving the trap never overlaps two requests.
    logic trap_pend_q, trap_pend_d;

    assign tgt     = redirect_pc;
    assign tgt_bad = redirect && (redirect_pc[1:0] != 2'b00);
`else
    logic unused_lsbs;

    assign tgt         = {redirect_pc[31:2], 2'b00};
    assign tgt_bad     = 1'b0;
    assign unused_lsbs = ^redirect_pc[1:0];
`endif

    // ------------------------------------------------------------------
    // Next-state / request logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        run_d        = 1'b1;
        req          = 1'b0;
        addr         = pc_q;
        deliver      = 1'b0;
        deliver_inst = hold_q;
`ifdef FETCH_MISALIGN_EN
        trap_pend_d  = trap_pend_q;
`endif

        case (state_q)
            S_IDLE: begin
                // run_q keeps the request low for the first cycle out of reset
                if (redirect) begin
                    pc_d = tgt;
                end else if (run_q) begin
                    req     = 1'b1;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect) begin
                    pc_d = tgt;
                    if (imem.imem_rvalid) begin
                        req  = 1'b1;
                        addr = tgt;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (imem.imem_rvalid) begin
                    if (adv) begin
                        deliver      = 1'b1;
                        deliver_inst = imem.imem_rdata;
                        req          = 1'b1;
                        addr         = pc_plus4;
                        pc_d         = pc_plus4;
                    end else begin
                        hold_d  = imem.imem_rdata;
                        state_d = S_HOLD;
                    end
                end
            end

            S_DROP: begin
                if (redirect) begin
                    pc_d = tgt;
                end
                if (imem.imem_rvalid) begin
                    req     = 1'b1;
                    addr    = redirect ? tgt : pc_q;
                    state_d = S_WAIT;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    hold_d  = NOP_INST;
                    req     = 1'b1;
                    addr    = tgt;
                    pc_d    = tgt;
                    state_d = S_WAIT;
                end else if (adv) begin
                    deliver      = 1'b1;
                    deliver_inst = hold_q;
                    hold_d       = NOP_INST;
                    req          = 1'b1;
                    addr         = pc_plus4;
                    pc_d         = pc_plus4;
                    state_d      = S_WAIT;
                end
            end

`ifdef FETCH_MISALIGN_EN
            S_TRAP: begin
                if (imem.imem_rvalid) begin
                    trap_pend_d = 1'b0;
                end
                if (redirect) begin
                    pc_d = tgt;
                    if (trap_pend_q && !imem.imem_rvalid) begin
                        state_d = S_DROP;
                    end else begin
                        req     = 1'b1;
                        addr    = tgt;
                        state_d = S_WAIT;
                    end
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef FETCH_MISALIGN_EN
        // A misaligned target overrides everything above: no request, no
        // delivery, and remember whether a response is still due.
        if (tgt_bad) begin
            state_d      = S_TRAP;
            req          = 1'b0;
            deliver      = 1'b0;
            hold_d       = NOP_INST;
            pc_d         = pc_q;
            trap_pend_d  = !imem.imem_rvalid &&
                           ((state_q == S_WAIT) || (state_q == S_DROP) ||
                            ((state_q == S_TRAP) && trap_pend_q));
        end
`endif
    end

    // ------------------------------------------------------------------
    // IF/ID register next value: redirect flushes, stall_d holds,
    // otherwise take the delivered instruction or insert a bubble.
    // ------------------------------------------------------------------
    always_comb begin
        pc_dec_d    = pc_dec_q;
        pc4_dec_d   = pc4_dec_q;
        inst_dec_d  = inst_dec_q;
        valid_dec_d = valid_dec_q;
        if (redirect) begin
            inst_dec_d  = NOP_INST;
            valid_dec_d = 1'b0;
        end else if (stall_d) begin
            // hold
        end else if (deliver) begin
            pc_dec_d    = pc_q;
            pc4_dec_d   = pc_plus4;
            inst_dec_d  = deliver_inst;
            valid_dec_d = 1'b1;
        end else begin
            inst_dec_d  = NOP_INST;
            valid_dec_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            hold_q      <= NOP_INST;
            run_q       <= 1'b0;
            pc_dec_q    <= 32'h0;
            pc4_dec_q   <= 32'h0;
            inst_dec_q  <= NOP_INST;
            valid_dec_q <= 1'b0;
`ifdef FETCH_MISALIGN_EN
            trap_pend_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_q      <= hold_d;
            run_q       <= run_d;
            pc_dec_q    <= pc_dec_d;
            pc4_dec_q   <= pc4_dec_d;
            inst_dec_q  <= inst_dec_d;
            valid_dec_q <= valid_dec_d;
`ifdef FETCH_MISALIGN_EN
            trap_pend_q <= trap_pend_d;
`endif
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = addr;
    assign pc_dec         = pc_dec_q;
    assign pc4_dec        = pc4_dec_q;
    assign inst_dec       = inst_dec_q;
    assign valid_dec      = valid_dec_q;

`ifdef FETCH_MISALIGN_EN
    assign fetch_misalign = (state_q == S_TRAP);
`else
    assign fetch_misalign = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed testbench for fetch_stage. A small instruction
//                memory model returns word = (addr << 5) | 0x13 after a
//                programmable latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_f;
    logic        stall_d;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_dec;
    logic [31:0] pc4_dec;
    logic [31:0] inst_dec;
    logic        valid_dec;
    logic        fetch_misalign;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_stage_if imem_bus ();

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem           (imem_bus.master),
        .pc_dec         (pc_dec),
        .pc4_dec        (pc4_dec),
        .inst_dec       (inst_dec),
        .valid_dec      (valid_dec),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clk = ~clk;

    // Instruction memory model: response appears lat cycles after the
    // request edge; it is not reset, so in-flight replies survive a DUT reset.
    int          lat = 1;
    int          cnt = 0;
    logic [31:0] pend_addr = 32'h0;

    always @(posedge clk) begin
        if (imem_bus.imem_req) begin
            cnt       <= lat;
            pend_addr <= imem_bus.imem_addr;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
        end
    end

    assign imem_bus.imem_rvalid = (cnt == 1);
    assign imem_bus.imem_rdata  = (cnt == 1) ? {pend_addr[26:0], 5'h13} : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle, apply this cycle's inputs, let them settle.
    task automatic cyc(input logic sf, input logic sd, input logic rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        stall_f     = sf;
        stall_d     = sd;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // ---- reset state
        cyc(0, 0, 0, 32'h0);
        cyc(0, 0, 0, 32'h0);
        chk("rst_req",      {31'h0, imem_bus.imem_req}, 32'h0);
        chk("rst_addr",     imem_bus.imem_addr,        32'h0);
        chk("rst_valid",    {31'h0, valid_dec},        32'h0);
        chk("rst_inst",     inst_dec,                  32'h13);
        chk("rst_pc",       pc_dec,                    32'h0);
        chk("rst_pc4",      pc4_dec,                   32'h0);
        chk("rst_misalign", {31'h0, fetch_misalign},   32'h0);
        rst_n = 1'b1;

        // ---- T1: back-to-back fetch with 1-cycle memory
        cyc(0, 0, 0, 32'h0);                       // C0
        chk("t1_req0",  {31'h0, imem_bus.imem_req}, 32'h1);
        chk("t1_addr0", imem_bus.imem_addr,         32'h0);
        cyc(0, 0, 0, 32'h0);                       // C1
        chk("t1_addr1", imem_bus.imem_addr,         32'h4);
        chk("t1_val1",  {31'h0, valid_dec},         32'h0);
        cyc(0, 0, 0, 32'h0);                       // C2
        chk("t1_addr2", imem_bus.imem_addr,         32'h8);
        chk("t1_pc0",   pc_dec,                     32'h0);
        chk("t1_pc4_0", pc4_dec,                    32'h4);
        chk("t1_inst0", inst_dec,                   32'h13);
        chk("t1_val2",  {31'h0, valid_dec},         32'h1);

        // ---- T2: stall while the 0x8 response returns
        cyc(1, 1, 0, 32'h0);                       // C3
        chk("t2_req3",  {31'h0, imem_bus.imem_req}, 32'h0);
        chk("t2_pc3",   pc_dec,                     32'h4);
        chk("t2_inst3", inst_dec,                   32'h93);
        cyc(1, 1, 0, 32'h0);                       // C4
        chk("t2_req4",  {31'h0, imem_bus.imem_req}, 32'h0);
        chk("t2_pc4",   pc_dec,                     32'h4);
        cyc(1, 1, 0, 32'h0);                       // C5
        chk("t2_req5",  {31'h0, imem_bus.imem_req}, 32'h0);
        chk("t2_val5",  {31'h0, valid_dec},         32'h1);
        cyc(0, 0, 0, 32'h0);                       // C6
        chk("t2_req6",  {31'h0, imem_bus.imem_req}, 32'h1);
        chk("t2_addr6", imem_bus.imem_addr,         32'hC);
        cyc(0, 0, 0, 32'h0);                       // C7
        chk("t2_pc7",   pc_dec,                     32'h8);
        chk("t2_inst7", inst_dec,                   32'h113);
        chk("t2_addr7", imem_bus.imem_addr,         32'h10);
        lat = 3;

        // ---- T3: redirect while a 3-cycle request is outstanding
        cyc(0, 0, 1, 32'h100);                     // C8
        chk("t3_req8",  {31'h0, imem_bus.imem_req}, 32'h0);
        chk("t3_pc8",   pc_dec,                     32'hC);
        cyc(0, 0, 0, 32'h0);                       // C9
        chk("t3_val9",  {31'h0, valid_dec},         32'h0);
        chk("t3_inst9", inst_dec,                   32'h13);
        chk("t3_req9",  {31'h0, imem_bus.imem_req}, 32'h0);
        cyc(0, 0, 0, 32'h0);                       // C10: stale reply dropped
        chk("t3_req10", {31'h0, imem_bus.imem_req}, 32'h1);
        chk("t3_addr10", imem_bus.imem_addr,        32'h100);
        chk("t3_val10", {31'h0, valid_dec},         32'h0);
        cyc(0, 0, 0, 32'h0);                       // C11
        chk("t3_val11", {31'h0, valid_dec},         32'h0);
        cyc(0, 0, 0, 32'h0);                       // C12
        chk("t3_val12", {31'h0, valid_dec},         32'h0);
        cyc(0, 0, 0, 32'h0);                       // C13
        chk("t3_addr13", imem_bus.imem_addr,        32'h104);
        chk("t3_val13", {31'h0, valid_dec},         32'h0);
        cyc(0, 0, 0, 32'h0);                       // C14
        chk("t3_pc14",  pc_dec,                     32'h100);
        chk("t3_pc4_14", pc4_dec,                   32'h104);
        chk("t3_inst14", inst_dec,                  32'h2013);
        chk("t3_val14", {31'h0, valid_dec},         32'h1);
        lat = 1;

        // ---- T4: redirect in HOLD while both stalls are asserted
        cyc(0, 0, 0, 32'h0);                       // C15
        cyc(1, 1, 0, 32'h0);                       // C16: 0x104 reply buffered
        chk("t4_req16", {31'h0, imem_bus.imem_req}, 32'h0);
        cyc(1, 1, 1, 32'h40);                      // C17
        chk("t4_req17", {31'h0, imem_bus.imem_req}, 32'h1);
        chk("t4_addr17", imem_bus.imem_addr,        32'h40);
        cyc(0, 0, 0, 32'h0);                       // C18
        chk("t4_val18", {31'h0, valid_dec},         32'h0);
        chk("t4_inst18", inst_dec,                  32'h13);
        chk("t4_addr18", imem_bus.imem_addr,        32'h44);
        cyc(0, 0, 0, 32'h0);                       // C19
        chk("t4_pc19",  pc_dec,                     32'h40);
        chk("t4_inst19", inst_dec,                  32'h813);
        chk("t4_addr19", imem_bus.imem_addr,        32'h48);
        lat = 3;

        // ---- T5: asynchronous reset with a request in flight
        cyc(0, 0, 0, 32'h0);                       // C20
        chk("t5_pc20",  pc_dec,                     32'h44);
        rst_n = 1'b0;
        #1;
        chk("t5_req_rst",  {31'h0, imem_bus.imem_req}, 32'h0);
        chk("t5_addr_rst", imem_bus.imem_addr,         32'h0);
        chk("t5_val_rst",  {31'h0, valid_dec},         32'h0);
        chk("t5_pc_rst",   pc_dec,                     32'h0);
        chk("t5_inst_rst", inst_dec,                   32'h13);
        cyc(0, 0, 0, 32'h0);                       // C21
        cyc(0, 0, 0, 32'h0);                       // C22: stale reply arrives
        rst_n = 1'b1;
        chk("t5_req22", {31'h0, imem_bus.imem_req}, 32'h0);
        cyc(0, 0, 0, 32'h0);                       // C23
        chk("t5_req23", {31'h0, imem_bus.imem_req}, 32'h1);
        chk("t5_addr23", imem_bus.imem_addr,        32'h0);
        chk("t5_val23", {31'h0, valid_dec},         32'h0);
        lat = 1;
        cyc(0, 0, 0, 32'h0);                       // C24
        chk("t5_addr24", imem_bus.imem_addr,        32'h4);
        chk("t5_val24", {31'h0, valid_dec},         32'h0);

`ifdef FETCH_MISALIGN_EN
        // ---- T6: misaligned redirect traps until an aligned redirect
        cyc(0, 0, 1, 32'h102);                     // C25
        chk("t6_pc25",  pc_dec,                     32'h0);
        chk("t6_req25", {31'h0, imem_bus.imem_req}, 32'h0);
        cyc(0, 0, 1, 32'h106);                     // C26
        chk("t6_mis26", {31'h0, fetch_misalign},    32'h1);
        chk("t6_req26", {31'h0, imem_bus.imem_req}, 32'h0);
        chk("t6_val26", {31'h0, valid_dec},         32'h0);
        cyc(0, 0, 1, 32'h200);                     // C27
        chk("t6_mis27", {31'h0, fetch_misalign},    32'h1);
        chk("t6_req27", {31'h0, imem_bus.imem_req}, 32'h1);
        chk("t6_addr27", imem_bus.imem_addr,        32'h200);
        cyc(0, 0, 0, 32'h0);                       // C28
        chk("t6_mis28", {31'h0, fetch_misalign},    32'h0);
        chk("t6_addr28", imem_bus.imem_addr,        32'h204);
        cyc(0, 0, 0, 32'h0);                       // C29
        chk("t6_pc29",  pc_dec,                     32'h200);
        chk("t6_inst29", inst_dec,                  32'h4013);
        chk("t6_val29", {31'h0, valid_dec},         32'h1);
`else
        // ---- low target bits are ignored without the trap feature
        cyc(0, 0, 1, 32'h102);                     // C25
        chk("t6_pc25",  pc_dec,                     32'h0);
        chk("t6_req25", {31'h0, imem_bus.imem_req}, 32'h1);
        chk("t6_addr25", imem_bus.imem_addr,        32'h100);
        chk("t6_mis25", {31'h0, fetch_misalign},    32'h0);
        cyc(0, 0, 0, 32'h0);                       // C26
        chk("t6_val26", {31'h0, valid_dec},         32'h0);
        chk("t6_addr26", imem_bus.imem_addr,        32'h104);
        cyc(0, 0, 0, 32'h0);                       // C27
        chk("t6_pc27",  pc_dec,                     32'h100);
        chk("t6_inst27", inst_dec,                  32'h2013);
        chk("t6_val27", {31'h0, valid_dec},         32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
